// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: tile sequencer for a row x col MAC array.
// Runs one tile as kernel load, flush, execute and drain. It pulls words from the
// L0 input FIFO, drives the array's registered 2-bit instruction, and counts
// completed output vectors on the last-column valid.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        one-cycle tile request, sampled only in IDLE
//   num_vec      activation vectors in the tile, latched on an accepted start
//   act_mode_i   activation mode, latched on an accepted start
//   l0_empty     L0 FIFO empty flag
//   l0_rd        L0 read strobe; the word is valid in the following cycle
//   inst_w       array instruction: 01 kernel load, 10 execute, 00 idle
//   act_mode     latched activation mode, stable for the whole tile
//   valid        array output valids; bit col-1 marks one output vector complete
//   busy         high in every state except IDLE
//   done         one-cycle pulse at tile end
//   err          drain timeout flag, sticky until the next accepted start
//   out_cnt      output vectors counted in this tile
module mac_array_ctrl #(
    parameter int unsigned row      = 8,
    parameter int unsigned col      = 8,
    parameter int unsigned cnt_bw   = 8,
    parameter int unsigned drain_to = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] num_vec,
    input  logic              act_mode_i,
    input  logic              l0_empty,
    output logic              l0_rd,
    output logic [1:0]        inst_w,
    output logic              act_mode,
    input  logic [col-1:0]    valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [cnt_bw-1:0] out_cnt
);

    localparam int unsigned KW = $clog2(col + 1);
    localparam int unsigned FW = $clog2(row + col + 1);
    localparam int unsigned DW = $clog2(drain_to + 1);

    localparam logic [KW-1:0] KLast = KW'(col);
    localparam logic [FW-1:0] FLast = FW'(row + col - 1);
    localparam logic [DW-1:0] DLast = DW'(drain_to - 1);

    localparam logic [1:0] InstIdle = 2'b00;
    localparam logic [1:0] InstLoad = 2'b01;
    localparam logic [1:0] InstExec = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StKload,
        StKflush,
        StExec,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     kcnt_q, kcnt_d;
    logic [FW-1:0]     ftmr_q, ftmr_d;
    logic [cnt_bw-1:0] vcnt_q, vcnt_d;
    logic [DW-1:0]     dtmr_q, dtmr_d;
    logic [cnt_bw-1:0] nvec_q, nvec_d;
    logic              mode_q, mode_d;
    logic              rd_q, rd_d;
    logic [1:0]        inst_q, inst_d;
    logic              busy_q;
    logic              done_q;
    logic              err_q, err_d;
    logic [cnt_bw-1:0] ocnt_q, ocnt_d;
    logic              count_en;

    // Only the last column's valid matters; the other bits are tied off here.
    logic unused_valid;
    assign unused_valid = ^valid;

    always_comb begin
        state_d  = state_q;
        kcnt_d   = kcnt_q;
        ftmr_d   = ftmr_q;
        vcnt_d   = vcnt_q;
        dtmr_d   = dtmr_q;
        nvec_d   = nvec_q;
        mode_d   = mode_q;
        err_d    = err_q;
        ocnt_d   = ocnt_q;
        rd_d     = 1'b0;
        count_en = 1'b0;

        // The word read this cycle reaches the array next cycle; the phase that
        // issued the read decides the opcode, so trailing words carry over.
        if (rd_q) begin
            inst_d = (state_q == StExec) ? InstExec : InstLoad;
        end else begin
            inst_d = InstIdle;
        end

        // Saturating output-vector counter; extra valids past num_vec are dropped.
        if ((state_q == StExec || state_q == StDrain) && valid[col-1] &&
            (ocnt_q != nvec_q)) begin
            count_en = 1'b1;
        end
        if (count_en) begin
            ocnt_d = ocnt_q + cnt_bw'(1);
        end

        // Reads are decided one cycle ahead so l0_rd is visible in the cycle the
        // counter accounts for it; kcnt/vcnt therefore include the current strobe.
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nvec_d = num_vec;
                    mode_d = act_mode_i;
                    err_d  = 1'b0;
                    ocnt_d = '0;
                    if (num_vec == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StKload;
                        rd_d    = !l0_empty;
                        kcnt_d  = KW'(rd_d);
                    end
                end
            end
            StKload: begin
                if (kcnt_q == KLast) begin
                    state_d = StKflush;
                    ftmr_d  = '0;
                end else begin
                    rd_d   = !l0_empty;
                    kcnt_d = kcnt_q + KW'(rd_d);
                end
            end
            StKflush: begin
                if (ftmr_q == FLast) begin
                    state_d = StExec;
                    rd_d    = !l0_empty;
                    vcnt_d  = cnt_bw'(rd_d);
                end else begin
                    ftmr_d = ftmr_q + FW'(1);
                end
            end
            StExec: begin
                if (vcnt_q == nvec_q) begin
                    state_d = StDrain;
                    dtmr_d  = '0;
                end else begin
                    rd_d   = !l0_empty;
                    vcnt_d = vcnt_q + cnt_bw'(rd_d);
                end
            end
            StDrain: begin
                // A count completing on the timeout cycle still ends the tile cleanly.
                if (ocnt_d == nvec_q) begin
                    state_d = StDone;
                end else if (dtmr_q == DLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    dtmr_d = dtmr_q + DW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            kcnt_q  <= '0;
            ftmr_q  <= '0;
            vcnt_q  <= '0;
            dtmr_q  <= '0;
            nvec_q  <= '0;
            mode_q  <= 1'b0;
            rd_q    <= 1'b0;
            inst_q  <= InstIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            ftmr_q  <= ftmr_d;
            vcnt_q  <= vcnt_d;
            dtmr_q  <= dtmr_d;
            nvec_q  <= nvec_d;
            mode_q  <= mode_d;
            rd_q    <= rd_d;
            inst_q  <= inst_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            err_q   <= err_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign l0_rd    = rd_q;
    assign inst_w   = inst_q;
    assign act_mode = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign out_cnt  = ocnt_q;

endmodule
